// File: rtl/soin_bpred_resolve_pkg.sv
// Shared meta field layout, FSM states and counter helper for the branch resolve unit.
package soin_bpred_resolve_pkg;

  localparam int BP_META_WIDTH = 18;
  localparam int META_IDX_LO   = 0;
  localparam int META_IDX_HI   = 11;
  localparam int META_CTR_LO   = 12;
  localparam int META_CTR_HI   = 13;
  localparam int META_RAS_LO   = 14;
  localparam int META_RAS_HI   = 17;
  localparam int DRAIN_W       = 8;

  typedef enum logic [1:0] {
    ST_IDLE     = 2'd0,
    ST_REDIRECT = 2'd1,
    ST_DRAIN    = 2'd2
  } state_t;

  // 2-bit saturating bimodal counter step
  function automatic logic [1:0] ctr_next(input logic [1:0] c, input logic taken);
    if (taken) return (c == 2'd3) ? c : c + 2'd1;
    else       return (c == 2'd0) ? c : c - 2'd1;
  endfunction

endpackage

// File: rtl/soin_bpred_resolve_stats.sv
// Branch and mispredict counters plus the debug read mux.
module soin_bpred_resolve_stats
  import soin_bpred_resolve_pkg::*;
(
  input  logic        clk,
  input  logic        reset,
  input  logic        inc_branch,
  input  logic        inc_miss,
  input  logic [1:0]  state_code,
  input  logic [31:0] debug_sel,
  output logic [31:0] debug_out
);

  logic [31:0] branch_cnt;
  logic [31:0] miss_cnt;

  always_ff @(posedge clk) begin
    if (!reset) begin
      branch_cnt <= '0;
      miss_cnt   <= '0;
    end else begin
      if (inc_branch) branch_cnt <= branch_cnt + 32'd1;
      if (inc_miss)   miss_cnt   <= miss_cnt + 32'd1;
    end
  end

  always_comb begin
    debug_out = '0;
    case (debug_sel)
      32'd0:   debug_out = branch_cnt;
      32'd1:   debug_out = miss_cnt;
      32'd2:   debug_out = {30'd0, state_code};
      default: debug_out = '0;
    endcase
  end

endmodule

// File: rtl/soin_bpred_resolve.sv
// Execute-side branch resolution: predictor update bus, mispredict redirect and wrong-path drain.
module soin_bpred_resolve
  import soin_bpred_resolve_pkg::*;
#(
  parameter int          META_W       = BP_META_WIDTH,
  parameter int unsigned DRAIN_CYCLES = 2
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              stall,
  input  logic              e_valid,
  input  logic [31:0]       e_PC,
  input  logic              e_is_branch,
  input  logic              e_is_cond,
  input  logic              e_is_call,
  input  logic              e_is_ret,
  input  logic              e_taken,
  input  logic [31:0]       e_target,
  input  logic              e_p_dir,
  input  logic [31:0]       e_p_target,
  input  logic [META_W-1:0] e_meta,
  output logic              execute_bpredictor_update,
  output logic [31:0]       execute_bpredictor_PC,
  output logic [31:0]       execute_bpredictor_target,
  output logic              execute_bpredictor_dir,
  output logic              execute_bpredictor_miss,
  output logic [META_W-1:0] execute_bpredictor_meta,
  output logic              execute_bpredictor_recover_ras,
  output logic              redirect_valid,
  output logic [31:0]       redirect_PC,
  input  logic              redirect_ack,
  input  logic [31:0]       debug_sel,
  output logic [31:0]       debug_out
);

  state_t             state, state_next;
  logic [DRAIN_W-1:0] drain_cnt, drain_next;
  logic               accept;
  logic               miss_c;
  logic               upd_c;
  logic [3:0]         ras_c;
  logic [META_W-1:0]  meta_c;

  assign accept = e_valid & ~stall & (state == ST_IDLE) & e_is_branch;
  assign miss_c = (e_taken != e_p_dir) | (e_taken & e_p_dir & (e_target != e_p_target));
  assign upd_c  = accept & (e_is_cond | e_is_call | e_is_ret);

  always_comb begin
    ras_c = e_meta[META_RAS_HI:META_RAS_LO];
    if (e_is_call)     ras_c = ras_c + 4'd1;
    else if (e_is_ret) ras_c = ras_c - 4'd1;
    meta_c = e_meta;
    meta_c[META_RAS_HI:META_RAS_LO] = ras_c;
    meta_c[META_CTR_HI:META_CTR_LO] = ctr_next(e_meta[META_CTR_HI:META_CTR_LO], e_taken);
  end

  // Exit DRAIN on the cycle the count would reach zero, so exactly DRAIN_CYCLES slots are dropped
  always_comb begin
    state_next = state;
    drain_next = drain_cnt;
    if (!stall) begin
      case (state)
        ST_IDLE: if (accept & miss_c) state_next = ST_REDIRECT;
        ST_REDIRECT: begin
          if (redirect_ack) begin
            state_next = ST_DRAIN;
            drain_next = DRAIN_W'(DRAIN_CYCLES);
          end
        end
        ST_DRAIN: begin
          if (drain_cnt <= DRAIN_W'(1)) begin
            state_next = ST_IDLE;
            drain_next = '0;
          end else begin
            drain_next = drain_cnt - DRAIN_W'(1);
          end
        end
        default: state_next = ST_IDLE;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      state                          <= ST_IDLE;
      drain_cnt                      <= '0;
      execute_bpredictor_update      <= 1'b0;
      execute_bpredictor_PC          <= '0;
      execute_bpredictor_target      <= '0;
      execute_bpredictor_dir         <= 1'b0;
      execute_bpredictor_miss        <= 1'b0;
      execute_bpredictor_meta        <= '0;
      execute_bpredictor_recover_ras <= 1'b0;
      redirect_valid                 <= 1'b0;
      redirect_PC                    <= '0;
    end else begin
      state                          <= state_next;
      drain_cnt                      <= drain_next;
      execute_bpredictor_update      <= upd_c;
      execute_bpredictor_recover_ras <= accept & miss_c;
      if (accept) begin
        execute_bpredictor_PC     <= e_PC;
        execute_bpredictor_target <= e_target;
        execute_bpredictor_dir    <= e_taken;
        execute_bpredictor_miss   <= miss_c;
        execute_bpredictor_meta   <= meta_c;
      end
      if (state == ST_IDLE && state_next == ST_REDIRECT) begin
        redirect_valid <= 1'b1;
        redirect_PC    <= e_target;
      end else if (state == ST_REDIRECT && state_next == ST_DRAIN) begin
        redirect_valid <= 1'b0;
      end
    end
  end

  soin_bpred_resolve_stats u_stats (
    .clk        (clk),
    .reset      (reset),
    .inc_branch (accept),
    .inc_miss   (accept & miss_c),
    .state_code (state),
    .debug_sel  (debug_sel),
    .debug_out  (debug_out)
  );

endmodule

// File: tb/tb_soin_bpred_resolve.sv
// Self-checking bench for soin_bpred_resolve: directed scenarios plus randomized traffic vs a reference model.
module tb_soin_bpred_resolve;

  logic        clk = 1'b0;
  logic        reset;
  logic        stall;
  logic        e_valid;
  logic [31:0] e_PC;
  logic        e_is_branch, e_is_cond, e_is_call, e_is_ret;
  logic        e_taken;
  logic [31:0] e_target;
  logic        e_p_dir;
  logic [31:0] e_p_target;
  logic [17:0] e_meta;
  logic        bp_update;
  logic [31:0] bp_pc;
  logic [31:0] bp_target;
  logic        bp_dir;
  logic        bp_miss;
  logic [17:0] bp_meta;
  logic        bp_rec;
  logic        redirect_valid;
  logic [31:0] redirect_PC;
  logic        redirect_ack;
  logic [31:0] debug_sel;
  logic [31:0] debug_out;

  int checks = 0;
  int fails  = 0;

  always #5 clk = ~clk;

  soin_bpred_resolve #(.META_W(18), .DRAIN_CYCLES(2)) dut (
    .clk                            (clk),
    .reset                          (reset),
    .stall                          (stall),
    .e_valid                        (e_valid),
    .e_PC                           (e_PC),
    .e_is_branch                    (e_is_branch),
    .e_is_cond                      (e_is_cond),
    .e_is_call                      (e_is_call),
    .e_is_ret                       (e_is_ret),
    .e_taken                        (e_taken),
    .e_target                       (e_target),
    .e_p_dir                        (e_p_dir),
    .e_p_target                     (e_p_target),
    .e_meta                         (e_meta),
    .execute_bpredictor_update      (bp_update),
    .execute_bpredictor_PC          (bp_pc),
    .execute_bpredictor_target      (bp_target),
    .execute_bpredictor_dir         (bp_dir),
    .execute_bpredictor_miss        (bp_miss),
    .execute_bpredictor_meta        (bp_meta),
    .execute_bpredictor_recover_ras (bp_rec),
    .redirect_valid                 (redirect_valid),
    .redirect_PC                    (redirect_PC),
    .redirect_ack                   (redirect_ack),
    .debug_sel                      (debug_sel),
    .debug_out                      (debug_out)
  );

  // Reference model: mode 0 idle, 1 waiting for ack, 2 dropping wrong-path slots
  int          m_mode;
  int          m_drain;
  logic        m_upd, m_rec, m_rv, m_dir, m_miss;
  logic [31:0] m_pc, m_tgt, m_rpc;
  logic [17:0] m_meta;
  logic [31:0] m_nbr, m_nmiss;

  task automatic model_edge();
    logic mis;
    int   c, r;
    if (!reset) begin
      m_mode = 0; m_drain = 0;
      m_upd = 0; m_rec = 0; m_rv = 0; m_dir = 0; m_miss = 0;
      m_pc = 0; m_tgt = 0; m_rpc = 0; m_meta = 0;
      m_nbr = 0; m_nmiss = 0;
      return;
    end
    m_upd = 0;
    m_rec = 0;
    if (stall) return;
    if (m_mode == 1) begin
      if (redirect_ack) begin
        m_mode = 2; m_drain = 2; m_rv = 0;
      end
    end else if (m_mode == 2) begin
      m_drain = m_drain - 1;
      if (m_drain == 0) m_mode = 0;
    end else if (e_valid && e_is_branch) begin
      mis = (e_taken != e_p_dir) || (e_taken && (e_target != e_p_target));
      c = int'(e_meta[13:12]);
      if (e_taken) c = (c < 3) ? c + 1 : 3;
      else         c = (c > 0) ? c - 1 : 0;
      r = int'(e_meta[17:14]);
      if (e_is_call)     r = (r + 1) % 16;
      else if (e_is_ret) r = (r + 15) % 16;
      m_meta = {r[3:0], c[1:0], e_meta[11:0]};
      m_pc = e_PC; m_tgt = e_target; m_dir = e_taken; m_miss = mis;
      m_upd = e_is_cond || e_is_call || e_is_ret;
      m_rec = mis;
      m_nbr = m_nbr + 1;
      if (mis) begin
        m_nmiss = m_nmiss + 1;
        m_mode = 1; m_rv = 1; m_rpc = e_target;
      end
    end
  endtask

  task automatic tick();
    model_edge();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_inputs();
    e_valid = 0; e_PC = 0; e_is_branch = 0; e_is_cond = 0; e_is_call = 0; e_is_ret = 0;
    e_taken = 0; e_target = 0; e_p_dir = 0; e_p_target = 0; e_meta = 0;
  endtask

  task automatic drive_branch(input logic [31:0] pc, input logic cond, input logic call,
                              input logic ret, input logic taken, input logic [31:0] tgt,
                              input logic pdir, input logic [31:0] ptgt, input logic [17:0] meta);
    e_valid = 1; e_is_branch = 1; e_PC = pc; e_is_cond = cond; e_is_call = call; e_is_ret = ret;
    e_taken = taken; e_target = tgt; e_p_dir = pdir; e_p_target = ptgt; e_meta = meta;
  endtask

  task automatic finish_redirect();
    idle_inputs();
    redirect_ack = 1; tick();
    redirect_ack = 0; tick(); tick();
  endtask

  task automatic test_reset();
    reset = 0; stall = 0; redirect_ack = 0; debug_sel = 0;
    idle_inputs();
    tick(); tick();
    checks++;
    if ({bp_update, bp_rec, bp_dir, bp_miss, redirect_valid} !== 5'b0) begin
      fails++; $display("FAIL reset_flags: got %b want 00000", {bp_update, bp_rec, bp_dir, bp_miss, redirect_valid});
    end
    checks++;
    if ({bp_pc, bp_target, redirect_PC, bp_meta} !== '0) begin
      fails++; $display("FAIL reset_buses: got pc=%h tgt=%h rpc=%h meta=%h want 0", bp_pc, bp_target, redirect_PC, bp_meta);
    end
    for (int s = 0; s < 3; s++) begin
      debug_sel = s; #1;
      checks++;
      if (debug_out !== 32'd0) begin
        fails++; $display("FAIL reset_debug%0d: got %0h want 0", s, debug_out);
      end
    end
    debug_sel = 0;
    reset = 1;
    tick();
  endtask

  task automatic test_hit();
    drive_branch(32'h200, 1, 0, 0, 1, 32'h300, 1, 32'h300, {4'd3, 2'd2, 12'h0AB});
    tick();
    idle_inputs();
    checks++;
    if ({bp_update, bp_miss, bp_rec, redirect_valid} !== 4'b1000) begin
      fails++; $display("FAIL hit_flags: got upd/miss/rec/rv=%b want 1000", {bp_update, bp_miss, bp_rec, redirect_valid});
    end
    checks++;
    if (bp_meta !== {4'd3, 2'd3, 12'h0AB} || bp_pc !== 32'h200 || bp_target !== 32'h300 || bp_dir !== 1'b1) begin
      fails++; $display("FAIL hit_bus: got meta=%h pc=%h tgt=%h dir=%b want %h 200 300 1", bp_meta, bp_pc, bp_target, bp_dir, {4'd3, 2'd3, 12'h0AB});
    end
    tick();
    checks++;
    if (bp_update !== 1'b0) begin
      fails++; $display("FAIL hit_pulse: got update=%b want 0", bp_update);
    end
  endtask

  task automatic test_saturate();
    drive_branch(32'h400, 1, 0, 0, 1, 32'h800, 1, 32'h800, {4'd0, 2'd3, 12'h123});
    tick();
    checks++;
    if (bp_meta[13:12] !== 2'd3 || bp_update !== 1'b1) begin
      fails++; $display("FAIL sat_high: got ctr=%0d upd=%b want 3 1", bp_meta[13:12], bp_update);
    end
    drive_branch(32'h410, 1, 0, 0, 0, 32'h414, 0, 32'h414, {4'd0, 2'd0, 12'h456});
    tick();
    idle_inputs();
    checks++;
    if (bp_meta[13:12] !== 2'd0 || bp_miss !== 1'b0) begin
      fails++; $display("FAIL sat_low: got ctr=%0d miss=%b want 0 0", bp_meta[13:12], bp_miss);
    end
  endtask

  task automatic test_mispredict_redirect();
    drive_branch(32'h100, 1, 0, 0, 0, 32'h104, 1, 32'h180, 18'h0);
    tick();
    idle_inputs();
    checks++;
    if ({bp_miss, bp_rec, redirect_valid, bp_update} !== 4'b1111 || redirect_PC !== 32'h104) begin
      fails++; $display("FAIL miss_redirect: got miss/rec/rv/upd=%b rpc=%h want 1111 104", {bp_miss, bp_rec, redirect_valid, bp_update}, redirect_PC);
    end
    for (int i = 0; i < 5; i++) begin
      drive_branch(32'h900, 1, 0, 0, 1, 32'h990, 0, 32'h0, 18'h0);
      tick();
      checks++;
      if (redirect_valid !== 1'b1 || redirect_PC !== 32'h104 || bp_update !== 1'b0 || bp_rec !== 1'b0) begin
        fails++; $display("FAIL redirect_hold%0d: got rv=%b rpc=%h upd=%b rec=%b want 1 104 0 0", i, redirect_valid, redirect_PC, bp_update, bp_rec);
      end
    end
    idle_inputs();
    redirect_ack = 1;
    tick();
    redirect_ack = 0;
    checks++;
    if (redirect_valid !== 1'b0) begin
      fails++; $display("FAIL redirect_ack: got rv=%b want 0", redirect_valid);
    end
    for (int i = 0; i < 3; i++) begin
      drive_branch(32'h600 + 32'(i * 4), 1, 0, 0, 1, 32'h700, 1, 32'h700, 18'h0);
      tick();
      checks++;
      if (bp_update !== ((i == 2) ? 1'b1 : 1'b0)) begin
        fails++; $display("FAIL drain_slot%0d: got update=%b want %b", i, bp_update, (i == 2));
      end
    end
    idle_inputs();
    tick();
  endtask

  task automatic test_ras_wrap();
    drive_branch(32'hA00, 0, 1, 0, 1, 32'hB00, 0, 32'h0, {4'd15, 2'd1, 12'h001});
    tick();
    checks++;
    if (bp_meta[17:14] !== 4'd0 || bp_miss !== 1'b1 || bp_update !== 1'b1) begin
      fails++; $display("FAIL ras_call_wrap: got ras=%0d miss=%b upd=%b want 0 1 1", bp_meta[17:14], bp_miss, bp_update);
    end
    finish_redirect();
    drive_branch(32'hC00, 0, 0, 1, 1, 32'hD00, 0, 32'h0, {4'd0, 2'd1, 12'h002});
    tick();
    checks++;
    if (bp_meta[17:14] !== 4'd15 || bp_rec !== 1'b1) begin
      fails++; $display("FAIL ras_ret_wrap: got ras=%0d rec=%b want 15 1", bp_meta[17:14], bp_rec);
    end
    finish_redirect();
  endtask

  task automatic test_reset_in_redirect();
    drive_branch(32'h140, 1, 0, 0, 1, 32'h200, 0, 32'h0, 18'h0);
    tick();
    idle_inputs();
    checks++;
    if (redirect_valid !== 1'b1) begin
      fails++; $display("FAIL rst_redir_setup: got rv=%b want 1", redirect_valid);
    end
    reset = 0;
    tick();
    checks++;
    if (redirect_valid !== 1'b0 || bp_update !== 1'b0) begin
      fails++; $display("FAIL rst_redir: got rv=%b upd=%b want 0 0", redirect_valid, bp_update);
    end
    debug_sel = 1; #1;
    checks++;
    if (debug_out !== 32'd0) begin
      fails++; $display("FAIL rst_miss_count: got %0h want 0", debug_out);
    end
    reset = 1;
    debug_sel = 0;
    tick();
  endtask

  task automatic test_stall();
    stall = 1;
    drive_branch(32'h240, 1, 0, 0, 1, 32'h280, 1, 32'h280, {4'd2, 2'd1, 12'hFFF});
    tick();
    checks++;
    if (bp_update !== 1'b0 || bp_rec !== 1'b0) begin
      fails++; $display("FAIL stall_accept: got upd=%b rec=%b want 0 0", bp_update, bp_rec);
    end
    stall = 0;
    tick();
    idle_inputs();
    checks++;
    if (bp_update !== 1'b1 || bp_meta !== {4'd2, 2'd2, 12'hFFF}) begin
      fails++; $display("FAIL stall_release: got upd=%b meta=%h want 1 %h", bp_update, bp_meta, {4'd2, 2'd2, 12'hFFF});
    end
    tick();
  endtask

  task automatic test_back_to_back();
    logic [31:0] exp_dbg;
    for (int n = 0; n < 600; n++) begin
      e_valid = ($urandom % 4) != 0;
      e_is_branch = ($urandom % 4) != 0;
      e_is_cond = 0; e_is_call = 0; e_is_ret = 0;
      case ($urandom % 5)
        0, 1: e_is_cond = 1;
        2: e_is_call = 1;
        3: e_is_ret = 1;
        default: ;
      endcase
      e_PC = $urandom & 32'hFFFF_FFFC;
      e_taken = $urandom % 2;
      e_target = e_taken ? ($urandom & 32'hFFFF_FFFC) : e_PC + 32'd4;
      e_p_dir = ($urandom % 3) != 0 ? e_taken : ~e_taken;
      e_p_target = ($urandom % 3) != 0 ? e_target : $urandom;
      e_meta = 18'($urandom);
      stall = ($urandom % 8) == 0;
      redirect_ack = ($urandom % 3) == 0;
      debug_sel = ($urandom % 10 == 0) ? $urandom : 32'($urandom_range(0, 2));
      tick();
      exp_dbg = (debug_sel == 0) ? m_nbr : (debug_sel == 1) ? m_nmiss :
                (debug_sel == 2) ? 32'(m_mode) : 32'd0;
      checks++;
      if ({bp_update, bp_rec, redirect_valid} !== {m_upd, m_rec, m_rv}) begin
        fails++; $display("FAIL rand_flags@%0d: got upd/rec/rv=%b want %b", n, {bp_update, bp_rec, redirect_valid}, {m_upd, m_rec, m_rv});
      end
      checks++;
      if (bp_pc !== m_pc || bp_target !== m_tgt || bp_dir !== m_dir || bp_miss !== m_miss || bp_meta !== m_meta) begin
        fails++; $display("FAIL rand_bus@%0d: got pc=%h tgt=%h dir=%b miss=%b meta=%h want %h %h %b %b %h",
                          n, bp_pc, bp_target, bp_dir, bp_miss, bp_meta, m_pc, m_tgt, m_dir, m_miss, m_meta);
      end
      if (m_rv) begin
        checks++;
        if (redirect_PC !== m_rpc) begin
          fails++; $display("FAIL rand_rpc@%0d: got %h want %h", n, redirect_PC, m_rpc);
        end
      end
      checks++;
      if (debug_out !== exp_dbg) begin
        fails++; $display("FAIL rand_debug@%0d: sel=%0h got %0h want %0h", n, debug_sel, debug_out, exp_dbg);
      end
    end
    stall = 0;
    redirect_ack = 0;
    idle_inputs();
  endtask

  initial begin
    test_reset();
    test_hit();
    test_saturate();
    test_mispredict_redirect();
    test_ras_wrap();
    test_reset_in_redirect();
    test_stall();
    test_back_to_back();
    $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
    $finish;
  end

endmodule
